// File: rtl/pc_seq_pkg.sv
// Shared encodings and defaults for the fetch-stage PC sequencer.
package pc_seq_pkg;

    localparam logic [1:0] JSEL_SEQ = 2'b00;
    localparam logic [1:0] JSEL_J   = 2'b01;
    localparam logic [1:0] JSEL_JR  = 2'b10;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/hazard inputs and fetch outputs of the PC sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16
);
    logic              stall_f;
    logic [1:0]        jump_sel;
    logic              branch_taken;
    logic [ADDR_W-1:0] pc_d;
    logic [IMM_W-1:0]  imm;
    logic [25:0]       index;
    logic [ADDR_W-1:0] reg_target;
    logic              exc_req;
    logic              eret_req;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] pc_f;
    logic              fetch_valid;
    logic              adel_f;

    modport master (
        output stall_f, jump_sel, branch_taken, pc_d, imm, index,
        output reg_target, exc_req, eret_req, epc,
        input  pc_f, fetch_valid, adel_f
    );

    modport slave (
        input  stall_f, jump_sel, branch_taken, pc_d, imm, index,
        input  reg_target, exc_req, eret_req, epc,
        output pc_f, fetch_valid, adel_f
    );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: exception, eret, j, jr, branch, sequential.
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                IMM_W      = 16,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR)
) (
    input  logic [ADDR_W-1:0] pc_f,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [IMM_W-1:0]  imm,
    input  logic [25:0]       index,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [ADDR_W-1:0] epc,
    input  logic [1:0]        jump_sel,
    input  logic              branch_taken,
    input  logic              exc_req,
    input  logic              eret_req,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect
);
    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    logic [ADDR_W-1:0] boff;
    logic [ADDR_W-1:0] jtgt;

    assign boff = {{(ADDR_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    assign jtgt = {pc_d[ADDR_W-1:28], index, 2'b00};

    always_comb begin
        next_pc  = pc_f + FOUR;
        redirect = 1'b1;
        if (exc_req) begin
            next_pc = EXC_VECTOR;
        end else if (eret_req) begin
            next_pc = epc;
        end else if (jump_sel == JSEL_J) begin
            next_pc = jtgt;
        end else if (jump_sel == JSEL_JR) begin
            next_pc = reg_target;
        end else if (branch_taken) begin
            next_pc = pc_d + FOUR + boff;
        end else begin
            redirect = 1'b0;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with boot hold, prioritised redirects and AdEL flag.
// Optional perf counters (stall_cnt, redirect_cnt) under PC_SEQUENCER_PERF_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                IMM_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR  = ADDR_W'(DEF_EXC_VECTOR),
    parameter logic [ADDR_W-1:0] IMEM_BASE   = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] IMEM_BYTES  = ADDR_W'(32'h0000_4000),
    parameter int                BOOT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
`ifdef PC_SEQUENCER_PERF_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [31:0]    redirect_cnt
`endif
);
    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int LAST_I = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);
    localparam state_t RST_STATE = (BOOT_CYCLES == 0) ? RUN : BOOT;
    // Window limit one bit wider so base+size cannot wrap.
    localparam logic [ADDR_W:0] LIMIT = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              force_upd;
    logic              pc_load;
    logic              valid;
    logic              bad_addr;

    pc_target_calc #(
        .ADDR_W     (ADDR_W),
        .IMM_W      (IMM_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_calc (
        .pc_f         (pc_q),
        .pc_d         (bus.pc_d),
        .imm          (bus.imm),
        .index        (bus.index),
        .reg_target   (bus.reg_target),
        .epc          (bus.epc),
        .jump_sel     (bus.jump_sel),
        .branch_taken (bus.branch_taken),
        .exc_req      (bus.exc_req),
        .eret_req     (bus.eret_req),
        .next_pc      (next_pc),
        .redirect     (redirect)
    );

    assign force_upd = bus.exc_req | bus.eret_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_nxt;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_nxt  = pc_q;
        pc_load = 1'b0;
        valid   = 1'b0;
        unique case (state_q)
            BOOT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = RUN;
            end
            RUN: begin
                valid   = 1'b1;
                pc_load = force_upd | ~bus.stall_f;
                if (pc_load) pc_nxt = next_pc;
            end
        endcase
    end

    assign bad_addr = (|pc_q[1:0])
                    | (pc_q < IMEM_BASE)
                    | ({1'b0, pc_q} >= LIMIT);

    assign bus.pc_f        = pc_q;
    assign bus.fetch_valid = valid;
    assign bus.adel_f      = valid & bad_addr;

`ifdef PC_SEQUENCER_PERF_EN
    logic [31:0] stall_q, redir_q;
    logic        stall_ev, redir_ev;

    assign stall_ev = (state_q == RUN) & bus.stall_f & ~force_upd;
    assign redir_ev = pc_load & redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            if (stall_ev && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (redir_ev && redir_q != '1) redir_q <= redir_q + 32'd1;
        end
    end

    assign stall_cnt    = stall_q;
    assign redirect_cnt = redir_q;
`else
    logic perf_unused;
    assign perf_unused = redirect;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Random + directed bench for pc_sequencer against a cycle-level reference model.
module tb_pc_sequencer;
    localparam logic [31:0] T_RESET = 32'h0000_3000;
    localparam logic [31:0] T_EXC   = 32'h0000_4180;
    localparam longint      T_BASE  = 64'h3000;
    localparam longint      T_BYTES = 64'h4000;
    localparam int          T_BOOT  = 2;

    logic clk = 1'b0;
    logic reset;

    pc_sequencer_if #(.ADDR_W(32), .IMM_W(16)) bus ();

`ifdef PC_SEQUENCER_PERF_EN
    logic [31:0] stall_cnt, redirect_cnt;
`endif

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef PC_SEQUENCER_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    int          m_boot;
    longint      m_sc, m_rc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_adel();
        longint a;
        a = longint'(m_pc);
        if (m_boot != 0) return 1'b0;
        return (a % 4 != 0) || (a < T_BASE) || (a >= T_BASE + T_BYTES);
    endfunction

    task automatic idle();
        bus.stall_f      = 1'b0;
        bus.jump_sel     = 2'b00;
        bus.branch_taken = 1'b0;
        bus.pc_d         = 32'h0;
        bus.imm          = 16'h0;
        bus.index        = 26'h0;
        bus.reg_target   = 32'h0;
        bus.exc_req      = 1'b0;
        bus.eret_req     = 1'b0;
        bus.epc          = 32'h0;
    endtask

    task automatic tick();
        logic [31:0] tgt, n_pc;
        int          n_boot;
        longint      n_sc, n_rc;
        bit          redir, upd;
        n_pc = m_pc; n_boot = m_boot; n_sc = m_sc; n_rc = m_rc;
        if (reset) begin
            n_pc = T_RESET; n_boot = T_BOOT; n_sc = 0; n_rc = 0;
        end else if (m_boot > 0) begin
            n_boot = m_boot - 1;
        end else begin
            redir = 1'b1;
            if (bus.exc_req) tgt = T_EXC;
            else if (bus.eret_req) tgt = bus.epc;
            else if (bus.jump_sel == 2'd1)
                tgt = (bus.pc_d & 32'hF000_0000) | (32'(bus.index) * 4);
            else if (bus.jump_sel == 2'd2) tgt = bus.reg_target;
            else if (bus.branch_taken)
                tgt = 32'(longint'(bus.pc_d) + 4
                          + longint'($signed(bus.imm)) * 4);
            else begin
                tgt = 32'(longint'(m_pc) + 4);
                redir = 1'b0;
            end
            upd = bus.exc_req || bus.eret_req || !bus.stall_f;
            if (upd) n_pc = tgt;
            if (bus.stall_f && !bus.exc_req && !bus.eret_req
                && n_sc < 64'hFFFF_FFFF) n_sc++;
            if (redir && upd && n_rc < 64'hFFFF_FFFF) n_rc++;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_boot = n_boot; m_sc = n_sc; m_rc = n_rc;
        check("pc_f", bus.pc_f, m_pc);
        check("fetch_valid", 32'(bus.fetch_valid), 32'(m_boot == 0));
        check("adel_f", 32'(bus.adel_f), 32'(exp_adel()));
`ifdef PC_SEQUENCER_PERF_EN
        check("stall_cnt", stall_cnt, 32'(m_sc));
        check("redirect_cnt", redirect_cnt, 32'(m_rc));
`endif
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return 32'h3000 + ($urandom_range(0, 4095) << 2);
    endfunction

    initial begin
        m_pc = '0; m_boot = 0; m_sc = 0; m_rc = 0;
        idle();
        reset = 1'b1;
        tick();
        check("rst_pc", bus.pc_f, 32'h3000);
        check("rst_valid", 32'(bus.fetch_valid), 32'd0);
        reset = 1'b0;
        tick();
        check("boot_hold", 32'(bus.fetch_valid), 32'd0);
        tick();
        check("boot_done", 32'(bus.fetch_valid), 32'd1);
        check("boot_pc", bus.pc_f, 32'h3000);
        tick();
        tick();
        check("seq_pc", bus.pc_f, 32'h3008);

        bus.pc_d = 32'h3010; bus.imm = 16'hFFFC; bus.branch_taken = 1'b1;
        tick();
        check("branch", bus.pc_f, 32'h3004);
        bus.jump_sel = 2'b01; bus.index = 26'h0000C10;
        tick();
        check("jump_over_br", bus.pc_f, 32'h3040);

        idle();
        bus.stall_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", bus.pc_f, 32'h3040);
        end
        bus.exc_req = 1'b1;
        tick();
        check("stall_exc", bus.pc_f, 32'h4180);
        idle();
        bus.exc_req = 1'b1; bus.eret_req = 1'b1; bus.epc = 32'h3100;
        tick();
        check("exc_over_eret", bus.pc_f, 32'h4180);

        idle();
        bus.jump_sel = 2'b10;
        bus.reg_target = 32'h3002;
        tick();
        check("misal_pc", bus.pc_f, 32'h3002);
        check("misal_adel", 32'(bus.adel_f), 32'd1);
        bus.reg_target = 32'h7000;
        tick();
        check("above_adel", 32'(bus.adel_f), 32'd1);
        bus.reg_target = 32'h6FFC;
        tick();
        check("top_ok", 32'(bus.adel_f), 32'd0);
        bus.reg_target = 32'hFFFF_FFFC;
        tick();
        idle();
        tick();
        check("wrap_pc", bus.pc_f, 32'h0);
        check("wrap_adel", 32'(bus.adel_f), 32'd1);

        bus.jump_sel = 2'b10; bus.reg_target = 32'h3050;
        tick();
        idle();
        reset = 1'b1; bus.exc_req = 1'b1;
        tick();
        check("rst_over_exc", bus.pc_f, 32'h3000);
        check("reboot", 32'(bus.fetch_valid), 32'd0);
        reset = 1'b0;
        idle();

        for (int i = 0; i < 800; i++) begin
            reset            = ($urandom_range(0, 99) == 0);
            bus.stall_f      = ($urandom_range(0, 3) == 0);
            bus.exc_req      = ($urandom_range(0, 15) == 0);
            bus.eret_req     = ($urandom_range(0, 15) == 0);
            bus.jump_sel     = 2'($urandom);
            bus.branch_taken = ($urandom_range(0, 2) == 0);
            bus.pc_d         = rand_addr();
            bus.imm          = 16'($urandom);
            bus.index        = 26'($urandom);
            bus.reg_target   = rand_addr();
            bus.epc          = rand_addr();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage PC register plus next-PC selection for the 5-stage MIPS pipeline; parametrised successor of the combinational next-PC logic.
- Owns the architectural F-stage PC and supports stall and boot hold.
- Applies prioritised redirects: exception vector, eret, D-stage jump/jr/branch, sequential.
- Flags fetch address errors (AdEL) for the F-stage instruction.

Parameters:
- ADDR_W, 32, PC/address width (≥ 28+2).
- IMM_W, 16, raw branch offset width; sign-extended internally.
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_BYTES, 32'h0000_4000, legal fetch window size in bytes.
- BOOT_CYCLES, 2, cycles after reset with fetch_valid=0 (0 allowed).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall_f  in  1  hold PC (hazard unit).
- jump_sel  in  2  D-stage op: 00 seq/branch, 01 j/jal, 10 jr/jalr, 11 reserved (treated as 00).
- branch_taken  in  1  D-stage branch resolved taken.
- pc_d  in  ADDR_W  PC of the D-stage instruction.
- imm  in  IMM_W  raw branch offset.
- index  in  26  j/jal instr_index.
- reg_target  in  ADDR_W  forwarded rs value for jr.
- exc_req  in  1  exception taken (from M stage).
- eret_req  in  1  eret committed.
- epc  in  ADDR_W  eret return address.
- pc_f  out  ADDR_W  current fetch PC.
- fetch_valid  out  1  pc_f is a real fetch.
- adel_f  out  1  pc_f misaligned or outside the fetch window.

Behaviour:
- FSM states: BOOT, RUN.
  - Reset → BOOT with counter=0, pc_f=RESET_PC, fetch_valid=0, adel_f=0.
  - BOOT: PC held; counter increments each cycle; → RUN when counter==BOOT_CYCLES-1. BOOT_CYCLES=0 enters RUN directly from reset.
  - RUN: fetch_valid=1.
- next_pc priority, highest first:
  1. exc_req → EXC_VECTOR.
  2. eret_req → epc.
  3. jump_sel==01 → {pc_d[ADDR_W-1:28], index, 2'b00}.
  4. jump_sel==10 → reg_target.
  5. branch_taken → pc_d + 4 + (sext(imm) << 2).
  6. Otherwise pc_f + 4.
- PC update:
  - exc_req or eret_req updates the PC even when stall_f=1.
  - stall_f=1 with no exc/eret holds the PC; D redirects are re-presented by the stalled D stage, so they are not buffered.
  - In BOOT, reset, exc_req and eret_req are ignored except reset; PC stays RESET_PC.
- One-cycle latency: the selected next_pc appears on pc_f after the next rising edge.
- Arithmetic is modulo 2^ADDR_W; 0xFFFF_FFFC + 4 wraps to 0, and the wrapped PC then raises adel_f.
- adel_f is combinational from pc_f:
  - set when pc_f[1:0]!=0, pc_f<IMEM_BASE, or pc_f≥IMEM_BASE+IMEM_BYTES;
  - window check is done at ADDR_W+1 bits to avoid overflow;
  - gated by fetch_valid.
- A misaligned target is still loaded; flagging is the sole response.
- Reset mid-operation overrides everything, including simultaneous exc_req.

Optional Feature:
- Macro: PC_SEQUENCER_PERF_EN.
- With the macro defined, add two outputs:
  - stall_cnt (32): counts RUN cycles with stall_f=1 and no exc/eret.
  - redirect_cnt (32): counts RUN cycles where next_pc came from priority 1–5 and the PC updated.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Without the macro: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package pc_seq_pkg holds:
  - jump_sel encodings JSEL_SEQ/JSEL_J/JSEL_JR;
  - FSM state enum {BOOT, RUN};
  - default RESET_PC / EXC_VECTOR constants.
- One natural sub-module: pc_target_calc, purely combinational next_pc selection and adders. pc_sequencer keeps the FSM, PC register, adel logic and counters.

Test Plan:
- Boot hold: reset, BOOT_CYCLES=2 → pc_f=0x3000 with fetch_valid=0 for 2 cycles, then 0x3000, 0x3004, 0x3008 with fetch_valid=1.
- Branch vs jump priority: pc_d=0x3010, imm=16'hFFFC, branch_taken=1 → pc_f=0x3004. Same inputs plus jump_sel=01, index=0x0000C10 → pc_f=0x3040.
- Stall vs exception: stall_f=1 for 3 cycles → pc_f frozen. stall_f=1 with exc_req=1 → pc_f=0x4180 next cycle. exc_req and eret_req together → 0x4180.
- adel: jump_sel=10, reg_target=0x3002 → pc_f=0x3002, adel_f=1. reg_target=0x7000 → adel_f=1. 0x6FFC → adel_f=0.
- Reset mid-run: after pc_f=0x3050, assert reset together with exc_req → pc_f=0x3000, BOOT re-entered.
- PERF_EN build: 5 stall cycles and 3 redirects → stall_cnt=5, redirect_cnt=3. Preload near saturation → counter holds at 0xFFFF_FFFF.
